// File: rtl/heap_pkg.sv
// Shared definitions for the pipelined max-heap: stage opcodes, issue FSM states,
// and sizing helpers derived from the number of heap levels.
package heap_pkg;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_QUERY  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_QRESP,
    S_CLR
  } state_t;

  function automatic int unsigned heap_cap(input int unsigned total_level);
    return (32'd1 << total_level) - 32'd1;
  endfunction

  // Long enough for an insert issued just before the query to settle through every level.
  function automatic int unsigned drain_cycles(input int unsigned total_level);
    return 2 * total_level + 1;
  endfunction

endpackage

// File: rtl/heap_issue_ctrl_if.sv
// Request, query-response and stage-1 issue signals of the heap front end.
// slave is the controller side, master the requester/stage side.
interface heap_issue_ctrl_if #(
  parameter int CNT_SIZE    = 20,
  parameter int ADDR_SIZE   = 28,
  parameter int TOTAL_LEVEL = 6
);

  logic                   ins_valid;
  logic                   ins_ready;
  logic [CNT_SIZE-1:0]    ins_cnt;
  logic [ADDR_SIZE-1:0]   ins_addr;

  logic                   qry_valid;
  logic                   qry_ready;
  logic [CNT_SIZE-1:0]    root_cnt;
  logic [ADDR_SIZE-1:0]   root_addr;

  logic                   qry_rsp_valid;
  logic [CNT_SIZE-1:0]    qry_rsp_cnt;
  logic [ADDR_SIZE-1:0]   qry_rsp_addr;
  logic                   qry_rsp_empty;

  logic                   valid_o;
  logic                   opcode_o;
  logic [CNT_SIZE-1:0]    wcnt_o;
  logic [ADDR_SIZE-1:0]   waddr_o;
  logic [TOTAL_LEVEL-1:0] insert_path_o;
  logic [TOTAL_LEVEL-1:0] index_o;
  logic [TOTAL_LEVEL-1:0] heap_element_cnt_o;

  modport slave (
    input  ins_valid, ins_cnt, ins_addr, qry_valid, root_cnt, root_addr,
    output ins_ready, qry_ready,
    output qry_rsp_valid, qry_rsp_cnt, qry_rsp_addr, qry_rsp_empty,
    output valid_o, opcode_o, wcnt_o, waddr_o, insert_path_o, index_o, heap_element_cnt_o
  );

  modport master (
    output ins_valid, ins_cnt, ins_addr, qry_valid, root_cnt, root_addr,
    input  ins_ready, qry_ready,
    input  qry_rsp_valid, qry_rsp_cnt, qry_rsp_addr, qry_rsp_empty,
    input  valid_o, opcode_o, wcnt_o, waddr_o, insert_path_o, index_o, heap_element_cnt_o
  );

endinterface

// File: rtl/heap_issue_ctrl.sv
// Heap front end: sequences inserts/queries into stage 1, tracks element count, serves root queries.
// Latency: insert accepted T -> valid_o in T+1; query accepted T -> response T+1+DRAIN_CYCLES+1 (T+2 when empty).
// Backpressure: ins_ready drops while issuing, draining, full or a query is pending; qry_ready only in IDLE/GAP.
module heap_issue_ctrl
  import heap_pkg::*;
#(
  parameter int CNT_SIZE    = 20,
  parameter int ADDR_SIZE   = 28,
  parameter int TOTAL_LEVEL = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  heap_issue_ctrl_if.slave       bus,
  output logic [TOTAL_LEVEL-1:0] heap_cnt,
  output logic                   full
);

  localparam int unsigned          DRAIN      = drain_cycles(TOTAL_LEVEL);
  localparam int                   DW         = $clog2(DRAIN + 1);
  localparam logic [TOTAL_LEVEL-1:0] CAP      = TOTAL_LEVEL'(heap_cap(TOTAL_LEVEL));
  localparam logic [DW-1:0]        DRAIN_LOAD = DW'(DRAIN);

  state_t         state_q, state_d;
  logic [DW-1:0]  drain_cnt;
  logic           ins_rdy, qry_rdy;
  logic           ins_acc, qry_acc;

  assign full          = (heap_cnt == CAP);
  assign bus.ins_ready = ins_rdy;
  assign bus.qry_ready = qry_rdy;
  assign bus.index_o   = '0;

  always_comb begin
    state_d = state_q;
    ins_rdy = 1'b0;
    qry_rdy = 1'b0;
    ins_acc = 1'b0;
    qry_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        // clear wins outright in IDLE, so neither request may handshake alongside it
        qry_rdy = !clear;
        ins_rdy = !full && !clear && !bus.qry_valid;
        if (clear) begin
          state_d = S_CLR;
        end else if (bus.qry_valid) begin
          qry_acc = 1'b1;
          state_d = (heap_cnt == '0) ? S_QRESP : S_DRAIN;
        end else if (bus.ins_valid && ins_rdy) begin
          ins_acc = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP: begin
        qry_rdy = 1'b1;
        ins_rdy = !full && !clear && !bus.qry_valid;
        if (bus.qry_valid) begin
          qry_acc = 1'b1;
          state_d = S_DRAIN;
        end else if (bus.ins_valid && ins_rdy) begin
          ins_acc = 1'b1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt <= DW'(1)) state_d = S_QRESP;
      end
      S_QRESP: state_d = S_IDLE;
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= S_IDLE;
      heap_cnt               <= '0;
      drain_cnt              <= '0;
      bus.valid_o            <= 1'b0;
      bus.opcode_o           <= OP_INSERT;
      bus.wcnt_o             <= '0;
      bus.waddr_o            <= '0;
      bus.insert_path_o      <= '0;
      bus.heap_element_cnt_o <= '0;
      bus.qry_rsp_valid      <= 1'b0;
      bus.qry_rsp_cnt        <= '0;
      bus.qry_rsp_addr       <= '0;
      bus.qry_rsp_empty      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus.valid_o  <= ins_acc;
      bus.opcode_o <= (state_d == S_DRAIN) ? OP_QUERY : OP_INSERT;

      if (ins_acc) begin
        bus.wcnt_o             <= bus.ins_cnt;
        bus.waddr_o            <= bus.ins_addr;
        bus.heap_element_cnt_o <= heap_cnt;
        bus.insert_path_o      <= heap_cnt + 1'b1;
        heap_cnt               <= heap_cnt + 1'b1;
      end else if (state_q == S_CLR) begin
        heap_cnt <= '0;
      end

      if (qry_acc && state_d == S_DRAIN) begin
        drain_cnt <= DRAIN_LOAD;
      end else if (state_q == S_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      bus.qry_rsp_valid <= (state_q == S_QRESP);
      if (state_q == S_QRESP) begin
        bus.qry_rsp_empty <= (heap_cnt == '0);
        bus.qry_rsp_cnt   <= (heap_cnt == '0) ? '0 : bus.root_cnt;
        bus.qry_rsp_addr  <= (heap_cnt == '0) ? '0 : bus.root_addr;
      end
    end
  end

endmodule

// File: tb/tb_heap_issue_ctrl.sv
// Directed bench for heap_issue_ctrl: stimulus pushes expected stage issues and query
// responses into queues; a negedge monitor pops and compares whenever the DUT emits one.
module tb_heap_issue_ctrl;
  import heap_pkg::*;

  localparam int CS    = 20;
  localparam int AS    = 28;
  localparam int TL    = 6;
  localparam int CAPV  = 63;
  localparam int DRN   = 13;

  typedef struct {
    int            cyc;
    logic [CS-1:0] cnt;
    logic [AS-1:0] addr;
    logic [TL-1:0] path;
    logic [TL-1:0] elem;
  } iss_t;

  typedef struct {
    int            cyc;
    logic [CS-1:0] cnt;
    logic [AS-1:0] addr;
    logic          empty;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [TL-1:0] heap_cnt;
  logic          full;

  heap_issue_ctrl_if #(.CNT_SIZE(CS), .ADDR_SIZE(AS), .TOTAL_LEVEL(TL)) bus ();

  heap_issue_ctrl #(.CNT_SIZE(CS), .ADDR_SIZE(AS), .TOTAL_LEVEL(TL)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .heap_cnt (heap_cnt),
    .full     (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_chk = 0;
  int            n_fail = 0;
  int            m_cnt = 0;
  logic [CS-1:0] m_max_cnt = '0;
  logic [AS-1:0] m_max_addr = '0;
  iss_t          iq[$];
  rsp_t          rq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every DUT output event is matched against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o) begin
        if (iq.size() == 0) begin
          flag("unexpected_issue");
        end else begin
          iss_t e;
          e = iq.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("issue_opcode", 64'(bus.opcode_o), 64'(OP_INSERT));
          chk("issue_wcnt", 64'(bus.wcnt_o), 64'(e.cnt));
          chk("issue_waddr", 64'(bus.waddr_o), 64'(e.addr));
          chk("issue_path", 64'(bus.insert_path_o), 64'(e.path));
          chk("issue_elem", 64'(bus.heap_element_cnt_o), 64'(e.elem));
          chk("issue_index", 64'(bus.index_o), 64'd0);
        end
      end
      if (bus.qry_rsp_valid) begin
        if (rq.size() == 0) begin
          flag("unexpected_rsp");
        end else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
          chk("rsp_cnt", 64'(bus.qry_rsp_cnt), 64'(r.cnt));
          chk("rsp_addr", 64'(bus.qry_rsp_addr), 64'(r.addr));
          chk("rsp_empty", 64'(bus.qry_rsp_empty), 64'(r.empty));
        end
      end
    end
  end

  task automatic insert(input logic [CS-1:0] c, input logic [AS-1:0] a);
    int w = 0;
    iss_t e;
    bus.ins_valid = 1'b1;
    bus.ins_cnt   = c;
    bus.ins_addr  = a;
    @(negedge clk);
    while (!bus.ins_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ins_ready) begin
      flag("ins_ready_timeout");
    end else begin
      e.cyc  = cyc + 1;
      e.cnt  = c;
      e.addr = a;
      e.path = TL'(m_cnt + 1);
      e.elem = TL'(m_cnt);
      iq.push_back(e);
      if (m_cnt == 0 || c > m_max_cnt) begin
        m_max_cnt  = c;
        m_max_addr = a;
      end
      m_cnt++;
      bus.root_cnt  = m_max_cnt;
      bus.root_addr = m_max_addr;
    end
    @(posedge clk);
    #1;
    bus.ins_valid = 1'b0;
  endtask

  task automatic query();
    int w = 0;
    rsp_t r;
    bus.qry_valid = 1'b1;
    @(negedge clk);
    while (!bus.qry_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.qry_ready) begin
      flag("qry_ready_timeout");
    end else begin
      r.cyc   = (m_cnt == 0) ? cyc + 2 : cyc + DRN + 2;
      r.empty = (m_cnt == 0);
      r.cnt   = (m_cnt == 0) ? '0 : m_max_cnt;
      r.addr  = (m_cnt == 0) ? '0 : m_max_addr;
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.qry_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while ((iq.size() != 0 || rq.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (iq.size() != 0 || rq.size() != 0) begin
      flag("drain_timeout");
      iq.delete();
      rq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ins_valid = 1'b0;
    bus.ins_cnt   = '0;
    bus.ins_addr  = '0;
    bus.qry_valid = 1'b0;
    bus.root_cnt  = '0;
    bus.root_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_opcode_o", 64'(bus.opcode_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.qry_rsp_valid), 64'd0);
    chk("rst_heap_cnt", 64'(heap_cnt), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ins_ready", 64'(bus.ins_ready), 64'd1);
    chk("rst_qry_ready", 64'(bus.qry_ready), 64'd1);
    @(posedge clk);
    #1;

    // Query on a fresh heap: fast path, empty response
    query();
    wait_done();

    // Back-to-back inserts, then a query while the last is still in flight
    insert(20'd5, 28'h0000a01);
    insert(20'd9, 28'h0000b02);
    insert(20'd3, 28'h0000c03);
    query();
    @(negedge clk);
    chk("drain_opcode", 64'(bus.opcode_o), 64'(OP_QUERY));
    chk("drain_valid_o", 64'(bus.valid_o), 64'd0);
    wait_done();
    chk("heap_cnt_after_3", 64'(heap_cnt), 64'd3);

    // clear during DRAIN is ignored
    query();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    wait_done();
    chk("heap_cnt_clear_in_drain", 64'(heap_cnt), 64'd3);

    // clear in IDLE beats simultaneous insert and query
    clear = 1'b1;
    bus.ins_valid = 1'b1;
    bus.ins_cnt   = 20'd77;
    bus.qry_valid = 1'b1;
    @(negedge clk);
    chk("clr_ins_ready", 64'(bus.ins_ready), 64'd0);
    chk("clr_qry_ready", 64'(bus.qry_ready), 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.ins_valid = 1'b0;
    bus.qry_valid = 1'b0;
    @(negedge clk);
    chk("clr_state_ins_ready", 64'(bus.ins_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("clr_heap_cnt", 64'(heap_cnt), 64'd0);
    chk("clr_ins_ready_back", 64'(bus.ins_ready), 64'd1);
    m_cnt = 0;
    @(posedge clk);
    #1;

    // Empty after clear: stale root must be masked to zero
    query();
    wait_done();

    // Fill to capacity
    for (int i = 0; i < CAPV; i++) insert(CS'(i * 3 + 1), AS'(i + 256));
    wait_done();
    chk("full_flag", 64'(full), 64'd1);
    chk("full_heap_cnt", 64'(heap_cnt), 64'(CAPV));

    // 64th insert stalls
    bus.ins_valid = 1'b1;
    bus.ins_cnt   = 20'd999;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("full_ins_ready", 64'(bus.ins_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.ins_valid = 1'b0;
    chk("full_heap_cnt_hold", 64'(heap_cnt), 64'(CAPV));

    query();
    wait_done();

    // Reset mid-drain discards the response
    query();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    rq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_cnt = 0;
    repeat (20) @(negedge clk);
    chk("reset_mid_drain_heap_cnt", 64'(heap_cnt), 64'd0);
    chk("reset_mid_drain_qry_ready", 64'(bus.qry_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
